random_access_memory: RTL and testbench

16 x 8-bit RAM of the 8-bit CPU, addressed by the memory address register's 4-bit address output. It is the consumer end of that address path.
- Run mode: the controller loads RAM from the bus (RI) or drives RAM onto the bus (RO).
- Manual mode: board switches plus a debounced write pushbutton program the byte at the current address.
- A display output always shows the addressed byte.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/button_synchronizer.sv | 34 +++
 rtl/random_access_memory.sv | 116 +++++++++++
 tb/tb_random_access_memory.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU datapath blocks.
//   ADDR_W / DATA_W : memory address and data widths
//   DEPTH           : number of RAM words
//   word_t          : one data word
//   ram_prog_state_t: manual-programming FSM states of the RAM
package cpu_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef logic [DATA_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        RELEASE = 2'd2
    } ram_prog_state_t;

endpackage

// File: rtl/button_synchronizer.sv
// Two-flop synchronizer plus rising-edge detector for a raw board button.
//   clk        : system clock
//   rst        : asynchronous active-high reset
//   async_in   : raw asynchronous button level
//   sync_out   : synchronized level (two clocks of latency)
//   rise_pulse : one-cycle high when sync_out goes 0 -> 1
module button_synchronizer (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out,
    output logic rise_pulse
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= async_in;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign sync_out   = r_sync;
    assign rise_pulse = r_sync & ~r_prev;

endmodule

// File: rtl/random_access_memory.sv
// 16 x 8 flop-based RAM with bus access in run mode and debounced
// pushbutton programming in manual mode.
//   clk, rst        : clock, asynchronous active-high reset (clears all words)
//   address         : word select from the memory address register
//   read_from_bus   : RI, store bus_in at the clock edge (run mode only)
//   write_to_bus    : RO, drive the addressed word to the bus (run mode only)
//   manual_mode     : 1 = programming mode, bus controls ignored
//   manual_write    : raw pushbutton, active-high
//   manual_switches : byte programmed by the pushbutton
//   bus_in          : bus value
//   bus_out         : addressed word when bus_out_en, else 0
//   bus_out_en      : bus drive request
//   contents        : addressed word, always (LED display)
module random_access_memory
    import cpu_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] address,
    input  logic              read_from_bus,
    input  logic              write_to_bus,
    input  logic              manual_mode,
    input  logic              manual_write,
    input  logic [DATA_W-1:0] manual_switches,
    input  logic [DATA_W-1:0] bus_in,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_out_en,
    output logic [DATA_W-1:0] contents
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    word_t           r_mem [DEPTH];
    ram_prog_state_t r_state;
    ram_prog_state_t w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic            w_btn_sync;
    logic            w_btn_rise;
    logic            w_man_we;
    logic            w_bus_we;

    // Synchronizer runs in every mode so a button held across a mode
    // change never produces a rise edge.
    button_synchronizer u_btn (
        .clk        (clk),
        .rst        (rst),
        .async_in   (manual_write),
        .sync_out   (w_btn_sync),
        .rise_pulse (w_btn_rise)
    );

    assign contents   = r_mem[address];
    assign bus_out_en = write_to_bus && !manual_mode;
    assign bus_out    = bus_out_en ? r_mem[address] : '0;
    assign w_bus_we   = read_from_bus && !manual_mode;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // RELEASE swallows bounces: any synchronized high restarts the
    // low-cycle count, so only a clean release returns to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_man_we    = 1'b0;
        case (r_state)
            IDLE: begin
                if (manual_mode && w_btn_rise) w_state_nxt = WRITE;
            end
            WRITE: begin
                if (manual_mode) begin
                    w_man_we    = 1'b1;
                    w_state_nxt = RELEASE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            RELEASE: begin
                if (!manual_mode) begin
                    w_state_nxt = IDLE;
                end else if (w_btn_sync) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Manual and bus write enables are mutually exclusive via manual_mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_man_we) begin
            r_mem[address] <= manual_switches;
        end else if (w_bus_we) begin
            r_mem[address] <= bus_in;
        end
    end

endmodule

// File: tb/tb_random_access_memory.sv
module tb_random_access_memory;
    import cpu_pkg::*;

    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] address;
    logic       read_from_bus, write_to_bus, manual_mode, manual_write;
    logic [7:0] manual_switches, bus_in;
    logic [7:0] bus_out, contents;
    logic       bus_out_en;

    logic [7:0] model [16];
    int         errors = 0;
    int         checks = 0;

    random_access_memory #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clk             (clk),
        .rst             (rst),
        .address         (address),
        .read_from_bus   (read_from_bus),
        .write_to_bus    (write_to_bus),
        .manual_mode     (manual_mode),
        .manual_write    (manual_write),
        .manual_switches (manual_switches),
        .bus_in          (bus_in),
        .bus_out         (bus_out),
        .bus_out_en      (bus_out_en),
        .contents        (contents)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Run-mode bus write of one word, mirrored in the model.
    task automatic bus_wr(input logic [3:0] a, input logic [7:0] d);
        manual_mode = 1'b0; address = a; bus_in = d; read_from_bus = 1'b1;
        tick();
        read_from_bus = 1'b0;
        model[a] = d;
    endtask

    task automatic sweep_model(input string tag);
        write_to_bus = 1'b0;
        for (int a = 0; a < 16; a++) begin
            address = 4'(a);
            #1;
            chk(tag, contents, model[a]);
        end
    endtask

    initial begin
        logic [3:0] a;
        logic [7:0] d;
        logic       ri, ro;
        logic [7:0] old;
        logic       pat [10];

        rst = 1'b1; address = '0; read_from_bus = 1'b0; write_to_bus = 1'b0;
        manual_mode = 1'b0; manual_write = 1'b0; manual_switches = '0; bus_in = '0;
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        tick(); tick();
        rst = 1'b0;
        tick();

        // Reset state via RO sweep
        write_to_bus = 1'b1;
        for (int i = 0; i < 16; i++) begin
            address = 4'(i);
            #1;
            chk("rst_bus_out", bus_out, 8'h00);
            chk("rst_bus_en", {7'd0, bus_out_en}, 8'h01);
            chk("rst_contents", contents, 8'h00);
        end
        write_to_bus = 1'b0;

        // Directed run-mode write
        bus_wr(4'h3, 8'hA5);
        address = 4'h3; #1; chk("ri_contents", contents, 8'hA5);
        address = 4'h2; #1; chk("ri_neighbor_lo", contents, 8'h00);
        address = 4'h4; #1; chk("ri_neighbor_hi", contents, 8'h00);
        address = 4'h3; write_to_bus = 1'b1; #1;
        chk("ro_bus_out", bus_out, 8'hA5);
        write_to_bus = 1'b0;

        // Randomized run-mode traffic, including RI and RO together
        for (int n = 0; n < 60; n++) begin
            a  = 4'($urandom_range(0, 15));
            d  = 8'($urandom);
            ri = 1'($urandom);
            ro = 1'($urandom);
            address = a; bus_in = d; read_from_bus = ri; write_to_bus = ro;
            #1;
            chk("rnd_bus_out", bus_out, ro ? model[a] : 8'h00);
            chk("rnd_bus_en", {7'd0, bus_out_en}, {7'd0, ro});
            chk("rnd_contents", contents, model[a]);
            tick();
            if (ri) model[a] = d;
            chk("rnd_after", contents, model[a]);
        end
        read_from_bus = 1'b0; write_to_bus = 1'b0;
        sweep_model("rnd_sweep");

        // Manual mode ignores bus controls
        manual_mode = 1'b1; read_from_bus = 1'b1; write_to_bus = 1'b1; bus_in = 8'h11;
        for (int n = 0; n < 4; n++) begin
            a = 4'($urandom_range(0, 15));
            address = a; #1;
            chk("man_bus_en", {7'd0, bus_out_en}, 8'h00);
            chk("man_bus_out", bus_out, 8'h00);
            tick();
            chk("man_no_ri", contents, model[a]);
        end
        read_from_bus = 1'b0; write_to_bus = 1'b0;

        // Bounced press: exactly one write, landing at edge 4
        bus_wr(4'h7, 8'hC3);
        manual_mode = 1'b1; address = 4'h7; manual_switches = 8'h3C;
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        old = model[7];
        for (int e = 1; e <= 10; e++) begin
            manual_write = pat[e-1];
            tick();
            chk($sformatf("press_edge%0d", e), contents, (e >= 4) ? 8'h3C : old);
        end
        model[7] = 8'h3C;
        // Re-press after a too-short release: swallowed
        manual_switches = 8'hFF;
        manual_write = 1'b0; tick(); tick();
        manual_write = 1'b1;
        for (int e = 0; e < 8; e++) tick();
        chk("short_release", contents, 8'h3C);
        manual_write = 1'b0;
        for (int e = 0; e < 10; e++) tick();
        chk("after_release", contents, 8'h3C);

        // Button held while manual_mode rises: no write until re-press
        bus_wr(4'h9, 8'h00);
        manual_write = 1'b1;
        for (int e = 0; e < 5; e++) tick();
        manual_mode = 1'b1; address = 4'h9; manual_switches = 8'h5A;
        for (int e = 0; e < 6; e++) tick();
        chk("held_no_write", contents, 8'h00);
        manual_write = 1'b0;
        for (int e = 0; e < DEB + 4; e++) tick();
        manual_write = 1'b1;
        tick(); tick(); tick();
        chk("repress_edge3", contents, 8'h00);
        tick();
        chk("repress_edge4", contents, 8'h5A);
        model[9] = 8'h5A;
        manual_write = 1'b0;
        for (int e = 0; e < 10; e++) tick();

        // manual_mode dropped while in WRITE: write suppressed
        bus_wr(4'hB, 8'h21);
        manual_mode = 1'b1; address = 4'hB; manual_switches = 8'h77;
        manual_write = 1'b1;
        tick(); tick(); tick();
        chk("drop_in_write", {6'd0, dut.r_state}, {6'd0, WRITE});
        manual_mode = 1'b0;
        tick();
        chk("drop_no_write", contents, 8'h21);
        chk("drop_idle", {6'd0, dut.r_state}, {6'd0, IDLE});
        manual_write = 1'b0;
        for (int e = 0; e < 6; e++) tick();

        sweep_model("final_sweep");

        // Asynchronous reset mid-cycle clears every word at once
        #2 rst = 1'b1;
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        sweep_model("async_rst");
        write_to_bus = 1'b1; address = 4'h3; #1;
        chk("async_rst_bus", bus_out, 8'h00);
        write_to_bus = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
